mem_bus_responder: RTL and testbench

- Target-side responder for the single-master readwrite/addr bus that the control FSM drives.
- Holds DEPTH 16-bit words and answers reads and writes with a four-phase req/ack handshake and a programmable number of wait states.
- Used as the register/sample-store endpoint for the player's control logic, and as a drop-in target for bench bring-up.

---
 rtl/mem_bus_responder.sv | 125 ++++++++++++
 tb/tb_mem_bus_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Word-addressed bus target: DEPTH x 16-bit store, word 0 is a read-only ID word.
// Latency: ack rises WAIT_CYCLES+1 edges after the req capture edge (WAIT_CYCLES+2 edges counting the capture edge).
// Backpressure: four-phase req/ack; ack is held until req drops, and a new req is taken only from IDLE.
// Optional build macro RESP_ADDR_CHECK_EN: flag addr >= DEPTH on err, suppress such writes, and return 0 for such reads.
module mem_bus_responder #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] ID_WORD     = 16'hA55A
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req,
    input  logic        readwrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_rw;
    logic [AW-1:0] r_idx;
    logic [15:0]   r_wdata;
    logic          r_oob;
    logic [15:0]   r_mem [DEPTH];

    logic          w_oob_in;
    logic          w_do_write;
    logic [15:0]   w_rd_word;

`ifdef RESP_ADDR_CHECK_EN
    // The range check is made on the full bus address at capture time.
    assign w_oob_in = (addr >= 16'(DEPTH));
`else
    // Upper address bits are deliberately ignored: addresses alias modulo DEPTH.
    logic w_addr_hi_unused;
    assign w_addr_hi_unused = ^addr[15:AW];
    assign w_oob_in         = 1'b0;
`endif

    // Word 0 never reads from storage; the store slot behind it stays at reset value.
    assign w_rd_word  = (r_idx == '0) ? ID_WORD : r_mem[r_idx];
    assign w_do_write = (r_state == S_RESP) && !r_rw && !r_oob && (r_idx != '0);
    assign busy       = (r_state != S_IDLE);

    // Control FSM: capture, wait states, single-cycle response, then hold ack until req drops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 16'h0000;
            r_oob   <= 1'b0;
            ack     <= 1'b0;
            rdata   <= 16'h0000;
            err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rw    <= readwrite;
                        r_idx   <= addr[AW-1:0];
                        r_wdata <= wdata;
                        r_oob   <= w_oob_in;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    // Bus inputs are ignored here; only the captured request matters.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_rw) begin
                        rdata <= r_oob ? 16'h0000 : w_rd_word;
                    end
                    err     <= r_oob;
                    ack     <= 1'b1;
                    r_state <= S_DRAIN;
                end
                default: begin
                    // S_DRAIN: release only once the master has dropped req.
                    if (!req) begin
                        ack     <= 1'b0;
                        err     <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Storage: committed only from RESP, so a reset mid-transaction never writes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_do_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized self-checking bench for mem_bus_responder against an array-based reference model.
// Inputs driven and outputs sampled on the falling clock edge.
// Each access is a full four-phase handshake with bounded waits.
module tb_mem_bus_responder;

    localparam int          DEPTH = 16;
    localparam int          WAITC = 2;
    localparam logic [15:0] ID    = 16'hA55A;

    logic        Clk     = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req     = 1'b0;
    logic        readwrite = 1'b0;
    logic [15:0] addr    = 16'h0000;
    logic [15:0] wdata   = 16'h0000;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_rdata;

    mem_bus_responder #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAITC),
        .ID_WORD    (ID)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .req      (req),
        .readwrite(readwrite),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        m_rdata = 16'h0000;
    endtask

    // One complete handshake. If swap is set, addr/wdata are changed to a2/d2
    // after the capture edge; the model still uses the captured a/d.
    task automatic access(input bit rw, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input bit swap,
                          input logic [15:0] a2, input logic [15:0] d2);
        int          idx;
        bit          oob;
        logic [15:0] exp_rd;
        int          n;
        bit          seen;
        idx    = int'(a) % DEPTH;
        oob    = 1'b0;
`ifdef RESP_ADDR_CHECK_EN
        oob    = (int'(a) >= DEPTH);
`endif
        exp_rd = 16'h0000;
        if (rw) begin
            if (!oob) exp_rd = (idx == 0) ? ID : m_mem[idx];
            m_rdata = exp_rd;
        end else if (!oob && idx != 0) begin
            m_mem[idx] = d;
        end

        @(negedge Clk);
        req = 1'b1; readwrite = rw; addr = a; wdata = d;
        n = 0; seen = 1'b0;
        // Edges counted from the capture edge inclusive.
        while (n < 40 && !seen) begin
            @(posedge Clk); @(negedge Clk);
            n++;
            if (n == 1) begin
                chk("busy_after_capture", {31'd0, busy}, 32'd1);
                if (swap) begin
                    addr = a2; wdata = d2;
                end
            end
            if (ack) seen = 1'b1;
        end
        chk("ack_latency", n, WAITC + 2);
        chk("err_with_ack", {31'd0, err}, {31'd0, oob});
        if (rw) chk("rdata", {16'd0, rdata}, {16'd0, exp_rd});
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); @(negedge Clk);
            chk("ack_hold", {31'd0, ack}, 32'd1);
        end
        req = 1'b0;
        @(posedge Clk); @(negedge Clk);
        chk("ack_fall", {31'd0, ack}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("rdata_held", {16'd0, rdata}, {16'd0, m_rdata});
    endtask

    task automatic rd(input logic [15:0] a);
        access(1'b1, a, 16'h0000, 0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input int hold);
        access(1'b0, a, d, hold, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        model_reset();
        // Power-on reset held for three cycles.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        Reset_n = 1'b1;

        // Seed a word so the mid-transaction reset also shows storage clearing.
        wr(16'd4, 16'h5555, 0);
        rd(16'd4);

        // Reset pulse in the middle of the wait states of a write.
        @(negedge Clk);
        req = 1'b1; readwrite = 1'b0; addr = 16'd3; wdata = 16'h1234;
        @(posedge Clk); @(negedge Clk);
        chk("midwait_busy", {31'd0, busy}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("midrst_ack",  {31'd0, ack},  32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        req = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        rd(16'd3);
        rd(16'd4);

        // Write/read round trip.
        wr(16'd5, 16'hBEEF, 0);
        rd(16'd5);

        // Word 0 is read-only and returns the ID word.
        wr(16'd0, 16'h0000, 0);
        wr(16'd0, 16'hFFFF, 1);
        rd(16'd0);

        // Long four-phase hold on a write.
        wr(16'd6, 16'hCAFE, 10);
        rd(16'd6);

        // Bus inputs changing during the wait states are ignored.
        wr(16'd7, 16'h0707, 0);
        access(1'b0, 16'd2, 16'h1111, 0, 1'b1, 16'd7, 16'h2222);
        rd(16'd2);
        rd(16'd7);

        // Out-of-range address 0x13 with DEPTH 16.
        wr(16'd3, 16'h0ABC, 0);
        wr(16'h0013, 16'h7777, 0);
        rd(16'd3);
        rd(16'h0013);

        // Randomized traffic, including out-of-range addresses and holds.
        for (int t = 0; t < 60; t++) begin
            logic [15:0] ra;
            logic [15:0] rdv;
            bit          rrw;
            int          rh;
            ra  = 16'($urandom_range(0, 2 * DEPTH - 1));
            rdv = 16'($urandom);
            rrw = 1'($urandom_range(0, 1));
            rh  = $urandom_range(0, 3);
            access(rrw, ra, rdv, rh, 1'b0, 16'h0, 16'h0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
